// File: rtl/mem_arbiter_pkg.sv
// Shared widths, source IDs and state encoding for the main-memory arbiter.
package mem_arbiter_pkg;

    // Main-memory channel widths
    localparam int MEM_ADDR_BITS   = 32;
    localparam int MEM_DATA_BITS   = 64;
    localparam int MEM_TAG_BITS    = 5;
    localparam int MEM_DATA_CYCLES = 4;

    // Source IDs carried in the MSB of the memory tag
    localparam logic MEM_SRC_IC = 1'b0;
    localparam logic MEM_SRC_DC = 1'b1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_WDATA = 1'b1
    } arb_state_e;

    // Beat counter width; a single-beat write still needs a 1-bit counter
    function automatic int beat_cnt_width(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker. Owns the favoured-port pointer; the pointer
// moves to the non-winner only when the caller signals an accepted grant.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic prio_reg;

    // On a conflict the favoured port wins; otherwise the lone requester wins
    assign grant_idx = (req == 2'b11) ? prio_reg : req[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req[gi] & (grant_idx == 1'(gi));
        end
    endgenerate

    // Favour the other port after every accepted grant
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_reg <= MEM_SRC_IC;
        end else if (advance) begin
            prio_reg <= ~grant_idx;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory request/data/response channel between the icache
// refill port and the dcache refill/writeback port. Requests are arbitrated
// round-robin, a write locks the channel for its data beats, and responses
// are steered back by the source bit prepended to the tag.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WRITE_BEATS   = MEM_DATA_CYCLES,
    parameter int ADDR_BITS     = MEM_ADDR_BITS,
    parameter int DATA_BITS     = MEM_DATA_BITS,
    parameter int TAG_BITS      = MEM_TAG_BITS
) (
    input  logic                   clk,
    input  logic                   reset,

    // icache refill port (reads only)
    input  logic                   ic_mem_req_valid,
    output logic                   ic_mem_req_ready,
    input  logic                   ic_mem_req_rw,
    input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
    input  logic [TAG_BITS-2:0]    ic_mem_req_tag,
    output logic                   ic_mem_resp_valid,
    output logic [TAG_BITS-2:0]    ic_mem_resp_tag,
    output logic [DATA_BITS-1:0]   ic_mem_resp_data,

    // dcache refill/writeback port
    input  logic                   dc_mem_req_valid,
    output logic                   dc_mem_req_ready,
    input  logic                   dc_mem_req_rw,
    input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic [TAG_BITS-2:0]    dc_mem_req_tag,
    input  logic                   dc_mem_req_data_valid,
    output logic                   dc_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
    output logic                   dc_mem_resp_valid,
    output logic [TAG_BITS-2:0]    dc_mem_resp_tag,
    output logic [DATA_BITS-1:0]   dc_mem_resp_data,

    // main-memory channel
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic [TAG_BITS-1:0]    mem_req_tag,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [TAG_BITS-1:0]    mem_resp_tag,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int              TW        = TAG_BITS - 1;
    localparam int              CW        = beat_cnt_width(WRITE_BEATS);
    localparam logic [CW-1:0]   LAST_BEAT = CW'(WRITE_BEATS - 1);

    arb_state_e     state_reg;
    logic           owner_reg;
    logic [CW-1:0]  cnt_reg;

    logic           in_idle;
    logic           data_path_en;
    logic           ic_req_ok;
    logic [1:0]     arb_req;
    logic [1:0]     arb_grant;
    logic           grant_idx;
    logic           req_fire;
    logic           beat_fire;
    logic [1:0]     resp_hit;

    // ------------------------------------------------------------------
    // Request arbitration
    // ------------------------------------------------------------------

    // An icache write has nowhere to get data from, so it is never offered
    assign ic_req_ok = ic_mem_req_valid & ~ic_mem_req_rw;

    // Requests compete only in IDLE and never while reset is held
    assign in_idle = ~reset & (state_reg == ARB_IDLE);
    assign arb_req = in_idle ? {dc_mem_req_valid, ic_req_ok} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .reset     (reset),
        .req       (arb_req),
        .advance   (req_fire),
        .grant     (arb_grant),
        .grant_idx (grant_idx)
    );

    assign mem_req_valid = |arb_req;
    assign req_fire      = mem_req_valid & mem_req_ready;

    // Winner's fields go to memory with its source ID prepended to the tag
    assign mem_req_rw   = (grant_idx == MEM_SRC_DC) ? dc_mem_req_rw : 1'b0;
    assign mem_req_addr = (grant_idx == MEM_SRC_DC) ? dc_mem_req_addr : ic_mem_req_addr;
    assign mem_req_tag  = {grant_idx,
                           (grant_idx == MEM_SRC_DC) ? dc_mem_req_tag : ic_mem_req_tag};

    assign ic_mem_req_ready = arb_grant[MEM_SRC_IC] & mem_req_ready;
    assign dc_mem_req_ready = arb_grant[MEM_SRC_DC] & mem_req_ready;

    // ------------------------------------------------------------------
    // Write data channel: open only while the dcache owns a write
    // ------------------------------------------------------------------
    assign data_path_en = ~reset & (state_reg == ARB_WDATA) & (owner_reg == MEM_SRC_DC);

    assign mem_req_data_valid    = data_path_en & dc_mem_req_data_valid;
    assign dc_mem_req_data_ready = data_path_en & mem_req_data_ready;
    assign mem_req_data_bits     = dc_mem_req_data_bits;
    assign mem_req_data_mask     = dc_mem_req_data_mask;

    assign beat_fire = mem_req_data_valid & mem_req_data_ready;

    // Lock the channel after an accepted write until its last beat is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ARB_IDLE;
            owner_reg <= MEM_SRC_IC;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (req_fire && mem_req_rw) begin
                        state_reg <= ARB_WDATA;
                        owner_reg <= grant_idx;
                        cnt_reg   <= '0;
                    end
                end
                ARB_WDATA: begin
                    if (beat_fire) begin
                        if (cnt_reg == LAST_BEAT) begin
                            state_reg <= ARB_IDLE;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response steering: live in every state, including reset
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign resp_hit[gi] = mem_resp_valid & (mem_resp_tag[TW] == 1'(gi));
        end
    endgenerate

    assign ic_mem_resp_valid = resp_hit[MEM_SRC_IC];
    assign dc_mem_resp_valid = resp_hit[MEM_SRC_DC];
    assign ic_mem_resp_tag   = mem_resp_tag[TW-1:0];
    assign dc_mem_resp_tag   = mem_resp_tag[TW-1:0];
    assign ic_mem_resp_data  = mem_resp_data;
    assign dc_mem_resp_data  = mem_resp_data;

`ifndef SYNTHESIS
    // An icache write request is a protocol violation by the requester
    ic_write_illegal: assert property (@(posedge clk) disable iff (reset)
        !(ic_mem_req_valid && ic_mem_req_rw));
`endif

endmodule
